// File: rtl/ip_pattern_injector_if.sv
// ip_pattern_injector_if: control, configuration and stream bundle for the IP pattern injector
interface ip_pattern_injector_if #(
    parameter int unsigned CNT_W = 8
);
    logic             clear;
    logic             start;
    logic [31:0]      inject_ip;
    logic [1:0]       byte_offset;
    logic [CNT_W-1:0] pre_words;
    logic [CNT_W-1:0] post_words;
    logic [7:0]       fill_byte;
    logic [31:0]      data_out;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport master (
        output clear, start, inject_ip, byte_offset, pre_words, post_words, fill_byte,
        input  data_out, data_valid, busy, done
    );

    modport slave (
        input  clear, start, inject_ip, byte_offset, pre_words, post_words, fill_byte,
        output data_out, data_valid, busy, done
    );
endinterface

// File: rtl/ip_pattern_injector.sv
// ip_pattern_injector: emits a bounded word stream carrying one IPv4 address at a byte offset, fill-padded; INJ_LFSR_FILL_EN selects LFSR fill bytes
module ip_pattern_injector #(
    parameter int unsigned CNT_W     = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic                  clk,
    input logic                  n_rst,
    ip_pattern_injector_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_IP_HI = 3'd2;
    localparam logic [2:0] S_IP_LO = 3'd3;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      ip_q, ip_d;
    logic [1:0]       off_q, off_d;
    logic [CNT_W-1:0] post_q, post_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       fill_q, fill_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       fv [4];

    // Sequencing and config latch; the state register names the word currently on data_out
    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        off_d   = off_q;
        post_d  = post_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                ip_d    = bus.inject_ip;
                off_d   = bus.byte_offset;
                post_d  = bus.post_words;
                fill_d  = bus.fill_byte;
                state_d = (bus.pre_words != '0) ? S_PRE : S_IP_HI;
                cnt_d   = (bus.pre_words != '0) ? bus.pre_words - 1'b1 : '0;
            end
            S_PRE: begin
                state_d = (cnt_q == '0) ? S_IP_HI : S_PRE;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end
            S_IP_HI: begin
                state_d = (off_q != 2'd0) ? S_IP_LO : (post_q != '0) ? S_POST : S_DONE;
                cnt_d   = (post_q != '0) ? post_q - 1'b1 : '0;
            end
            S_IP_LO: begin
                state_d = (post_q != '0) ? S_POST : S_DONE;
                cnt_d   = (post_q != '0) ? post_q - 1'b1 : '0;
            end
            S_POST: begin
                state_d = (cnt_q == '0) ? S_DONE : S_POST;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.clear) begin
            state_d = S_IDLE;
            ip_d    = '0;
            off_d   = '0;
            post_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
        end
    end

`ifdef INJ_LFSR_FILL_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lf [5];
    logic [2:0] nfill;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Fill bytes of the next word take successive LFSR values; the generator restarts from the seed on each accepted start
    always_comb begin
        lf[0] = (state_q == S_IDLE) ? LFSR_SEED : lfsr_q;
        for (int i = 1; i < 5; i++) lf[i] = lfsr_step(lf[i-1]);
        for (int i = 0; i < 4; i++) fv[i] = lf[i];
        nfill = (state_d == S_PRE || state_d == S_POST) ? 3'd4 :
                (state_d == S_IP_HI) ? {1'b0, off_d} :
                (state_d == S_IP_LO) ? 3'd4 - {1'b0, off_d} : 3'd0;
        lfsr_d = bus.clear ? LFSR_SEED : lf[nfill];
    end

    // LFSR state register
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
`else
    // Every fill byte is the latched pad value
    always_comb begin
        for (int i = 0; i < 4; i++) fv[i] = fill_d;
    end
`endif

    // Build the word for the state being entered so the outputs can be registered without a bubble
    always_comb begin
        case (state_d)
            S_PRE, S_POST: data_d = {fv[0], fv[1], fv[2], fv[3]};
            S_IP_HI: data_d = (off_d == 2'd0) ? ip_d :
                              (off_d == 2'd1) ? {fv[0], ip_d[31:8]} :
                              (off_d == 2'd2) ? {fv[0], fv[1], ip_d[31:16]} :
                                                {fv[0], fv[1], fv[2], ip_d[31:24]};
            S_IP_LO: data_d = (off_d == 2'd1) ? {ip_d[7:0], fv[0], fv[1], fv[2]} :
                              (off_d == 2'd2) ? {ip_d[15:0], fv[0], fv[1]} :
                                                {ip_d[23:0], fv[0]};
            default: data_d = '0;
        endcase
        valid_d = (state_d == S_PRE) || (state_d == S_IP_HI) || (state_d == S_IP_LO) || (state_d == S_POST);
        busy_d  = valid_d;
        done_d  = (state_d == S_DONE);
    end

    // State, latched configuration and registered outputs
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
            off_q   <= '0;
            post_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            off_q   <= off_d;
            post_q  <= post_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ip_pattern_injector.sv
// tb_ip_pattern_injector: directed-vector bench for ip_pattern_injector (default build, plain fill byte)
module tb_ip_pattern_injector;
    logic clk = 1'b0;
    logic n_rst;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] cap_data [600];

    ip_pattern_injector_if #(.CNT_W(8)) bus ();

    ip_pattern_injector #(.CNT_W(8), .LFSR_SEED(8'hA5)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear       = 1'b0;
        bus.start       = 1'b0;
        bus.inject_ip   = '0;
        bus.byte_offset = '0;
        bus.pre_words   = '0;
        bus.post_words  = '0;
        bus.fill_byte   = '0;
    endtask

    task automatic launch(input logic [31:0] ip, input logic [1:0] k, input logic [7:0] pre,
                          input logic [7:0] post, input logic [7:0] fill);
        bus.inject_ip   = ip;
        bus.byte_offset = k;
        bus.pre_words   = pre;
        bus.post_words  = post;
        bus.fill_byte   = fill;
        bus.start       = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        n_rst = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.data_out, bus.data_valid, bus.busy, bus.done} !== 35'h0) begin
            errors++;
            $display("FAIL reset_hold got data=%h v=%b b=%b d=%b required all zero", bus.data_out, bus.data_valid, bus.busy, bus.done);
        end
        n_rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.data_out, bus.data_valid, bus.busy, bus.done} !== 35'h0) begin
            errors++;
            $display("FAIL reset_idle got data=%h v=%b b=%b d=%b required all zero", bus.data_out, bus.data_valid, bus.busy, bus.done);
        end
    endtask

    // Start at cycle 0, expect the listed words on cycles 1..n, done at n+1, quiet at n+2
    task automatic test_stream(input string name, input logic [31:0] ip, input logic [1:0] k,
                               input logic [7:0] pre, input logic [7:0] post, input logic [7:0] fill,
                               input logic [31:0] exp_w [$]);
        int n;
        logic ev, ed;
        logic [31:0] ew;
        n = exp_w.size();
        launch(ip, k, pre, post, fill);
        for (int c = 1; c <= n + 2; c++) begin
            tick();
            bus.start = 1'b0;
            bus.inject_ip = 32'hFFFF_FFFF;
            bus.fill_byte = 8'h99;
            ev = (c <= n);
            ed = (c == n + 1);
            ew = ev ? exp_w[c-1] : 32'h0;
            if (ev) cap_data[c-1] = bus.data_out;
            vectors++;
            if (bus.data_out !== ew) begin
                errors++;
                $display("FAIL %s data c%0d got %h required %h", name, c, bus.data_out, ew);
            end
            vectors++;
            if ({bus.data_valid, bus.busy, bus.done} !== {ev, ev, ed}) begin
                errors++;
                $display("FAIL %s flags c%0d got v%b b%b d%b required v%b b%b d%b", name, c,
                         bus.data_valid, bus.busy, bus.done, ev, ev, ed);
            end
        end
    endtask

    task automatic test_k0();
        test_stream("k0_pre2_post1", 32'hC0A80101, 2'd0, 8'd2, 8'd1, 8'h00,
                    '{32'h00000000, 32'h00000000, 32'hC0A80101, 32'h00000000});
    endtask

    task automatic test_k2();
        test_stream("k2_fillff", 32'h0A000001, 2'd2, 8'd0, 8'd0, 8'hFF,
                    '{32'hFFFF0A00, 32'h0001FFFF});
    endtask

    task automatic test_k1_post();
        test_stream("k1_post2", 32'h11223344, 2'd1, 8'd0, 8'd2, 8'h5A,
                    '{32'h5A112233, 32'h445A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A});
    endtask

    task automatic test_k3_match();
        logic [7:0] bytes [12];
        logic found;
        test_stream("k3_pre1", 32'h01020304, 2'd3, 8'd1, 8'd0, 8'h00,
                    '{32'h00000000, 32'h00000001, 32'h02030400});
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < 4; b++) bytes[w*4+b] = cap_data[w][31-8*b -: 8];
        found = 1'b0;
        for (int i = 0; i <= 8; i++)
            if ({bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]} == 32'h01020304) found = 1'b1;
        vectors++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL k3_match got found=%b required 1", found);
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] exp_w [7];
        int dones;
        logic ev;
        exp_w = '{32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE,
                  32'hEE112233, 32'h44EEEEEE};
        dones = 0;
        launch(32'h11223344, 2'd1, 8'd5, 8'd0, 8'hEE);
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus.start = (c == 2 || c == 7 || c == 8);
            bus.inject_ip = 32'hDEADBEEF;
            bus.byte_offset = 2'd0;
            bus.pre_words = 8'd0;
            ev = (c <= 7);
            if (bus.done) dones++;
            vectors++;
            if (bus.data_out !== (ev ? exp_w[c-1] : 32'h0) || bus.data_valid !== ev || bus.busy !== ev) begin
                errors++;
                $display("FAIL ignored_start c%0d got data=%h v%b b%b required data=%h v%b", c,
                         bus.data_out, bus.data_valid, bus.busy, ev ? exp_w[c-1] : 32'h0, ev);
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignored_start done_count got %0d required 1", dones);
        end
    endtask

    task automatic test_clear();
        logic [31:0] ew;
        logic ev, ed;
        launch(32'hAABBCCDD, 2'd0, 8'd10, 8'd0, 8'h55);
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.start = 1'b0;
            bus.clear = (c == 4);
            if (c == 6) launch(32'h01020304, 2'd0, 8'd0, 8'd0, 8'h00);
            ev = (c <= 4) || (c == 7);
            ed = (c == 8);
            ew = (c <= 4) ? 32'h55555555 : (c == 7) ? 32'h01020304 : 32'h0;
            vectors++;
            if (bus.data_out !== ew || {bus.data_valid, bus.busy, bus.done} !== {ev, ev, ed}) begin
                errors++;
                $display("FAIL clear c%0d got data=%h v%b b%b d%b required data=%h v%b b%b d%b", c,
                         bus.data_out, bus.data_valid, bus.busy, bus.done, ew, ev, ev, ed);
            end
        end
    endtask

    task automatic test_async_reset();
        launch(32'hCAFEF00D, 2'd0, 8'd10, 8'd0, 8'h77);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.data_out !== 32'h77777777 || bus.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got data=%h v%b required 77777777 v1", bus.data_out, bus.data_valid);
        end
        #2;
        n_rst = 1'b0;
        #1;
        vectors++;
        if ({bus.data_out, bus.data_valid, bus.busy, bus.done} !== 35'h0) begin
            errors++;
            $display("FAIL async_immediate got data=%h v%b b%b d%b required all zero", bus.data_out, bus.data_valid, bus.busy, bus.done);
        end
        tick();
        n_rst = 1'b1;
        tick();
        vectors++;
        if ({bus.data_out, bus.data_valid, bus.busy, bus.done} !== 35'h0) begin
            errors++;
            $display("FAIL async_release got data=%h v%b b%b d%b required all zero", bus.data_out, bus.data_valid, bus.busy, bus.done);
        end
        test_stream("after_async", 32'hC0A80101, 2'd0, 8'd0, 8'd0, 8'h00, '{32'hC0A80101});
    endtask

    task automatic test_max_counts();
        int nvalid, dones, cyc;
        logic seen_done;
        nvalid = 0;
        dones = 0;
        seen_done = 1'b0;
        cyc = 0;
        launch(32'h12345678, 2'd2, 8'd255, 8'd255, 8'h3C);
        while (!seen_done && cyc < 600) begin
            tick();
            bus.start = 1'b0;
            cyc++;
            if (bus.data_valid) begin
                cap_data[nvalid] = bus.data_out;
                nvalid++;
            end
            if (bus.done) begin
                dones++;
                seen_done = 1'b1;
            end
        end
        vectors++;
        if (!seen_done) begin
            errors++;
            $display("FAIL max_timeout no done within %0d cycles", cyc);
        end
        vectors++;
        if (nvalid !== 512) begin
            errors++;
            $display("FAIL max_len got %0d words required 512", nvalid);
        end
        vectors++;
        if (cap_data[254] !== 32'h3C3C3C3C || cap_data[255] !== 32'h3C3C1234 ||
            cap_data[256] !== 32'h56783C3C || cap_data[511] !== 32'h3C3C3C3C) begin
            errors++;
            $display("FAIL max_words got %h %h %h %h required 3c3c3c3c 3c3c1234 56783c3c 3c3c3c3c",
                     cap_data[254], cap_data[255], cap_data[256], cap_data[511]);
        end
        tick();
        vectors++;
        if ({bus.data_valid, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL max_idle got v%b b%b d%b required 000", bus.data_valid, bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_k0();
        test_k2();
        test_k3_match();
        test_k1_post();
        test_ignored_start();
        test_clear();
        test_async_reset();
        test_max_counts();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ip_pattern_injector.md
Name: ip_pattern_injector

Overview:
Transmit-side counterpart to the IP address matcher in the sniffer datapath. Generates a bounded stream of 32-bit words that carries one programmed IPv4 address at a programmable byte alignment, padded with fill bytes before and after. Drives the matcher's data_in path for self-test and bring-up, and serves as the Atom-controlled pattern source on the bench.
- Byte order is big-endian: byte 0 of a word is bits [31:24]; earlier words precede later words.

Parameters:
CNT_W, 8, width of the pre_words/post_words counts.
LFSR_SEED, 8'hA5, LFSR reset/clear value; used only with INJ_LFSR_FILL_EN; must be nonzero.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns block to IDLE
start  input  1  begin one injection; sampled only in IDLE
inject_ip  input  32  address to embed; latched on accepted start
byte_offset  input  2  byte index (0-3) of ip[31:24] within its first word; latched on start
pre_words  input  CNT_W  count of all-fill words before the IP; latched on start
post_words  input  CNT_W  count of all-fill words after the IP; latched on start
fill_byte  input  8  pad byte value; latched on start
data_out  output  32  stream word
data_valid  output  1  data_out holds a stream word this cycle
busy  output  1  high from the cycle after an accepted start through the last valid word
done  output  1  one-cycle pulse after the last valid word

Behaviour:
- Reset (n_rst=0, async): state=IDLE; data_out=0, data_valid=0, busy=0, done=0; latched config=0.
- clear=1 at an edge, with n_rst high: same values as reset. Takes priority over start. No done pulse.
- All outputs are registered.
- FSM states: IDLE, PRE, IP_HI, IP_LO, POST, DONE.
- IDLE: if start=1, latch all config. Next state is PRE if pre_words!=0, else IP_HI.
- start outside IDLE is ignored, including start during DONE.
- First valid word appears the cycle after start is accepted.
- PRE: emit {4{fill}}. Run pre_words cycles, then go to IP_HI.
- IP_HI, with k = byte_offset:
  - Bytes 0..k-1 = fill. Bytes k..3 = ip[31:24], ip[23:16], ... in that order.
  - k=0: word = inject_ip. Next state is POST if post_words!=0, else DONE.
  - k!=0: next state is IP_LO.
- IP_LO (k!=0 only): bytes 0..k-1 = the remaining k low-order IP bytes in order. Bytes k..3 = fill. Then go to POST or DONE by the same rule.
- POST: emit {4{fill}}. Run post_words cycles, then go to DONE.
- DONE: data_valid=0, busy=0, done=1 for exactly one cycle, then go to IDLE.
- Total valid words = pre_words + (k==0 ? 1 : 2) + post_words, emitted back-to-back with no gaps.
- data_out=0 whenever data_valid=0.
- Counters load count-1 on entry and do not wrap. Maximum count is 2^CNT_W-1 and is legal.
- Input changes after start have no effect until the next run.
- The stream is compatible with a downstream matcher that takes one word per cycle with no backpressure. No ready handshake exists.

Optional Feature:
INJ_LFSR_FILL_EN:
- Defined: every fill byte comes from an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - LFSR is loaded with LFSR_SEED on reset/clear and on each accepted start.
  - Advances once per fill byte consumed, from byte 0 toward byte 3 within a word.
  - fill_byte is ignored.
- Fill bytes are not guaranteed to avoid forming the IP. The bench checks matches against its own model.
- Not defined: fill is the latched fill_byte and no LFSR logic is synthesized.

Test Plan:
1. ip=C0A80101, k=0, pre=2, post=1, fill=00, start at cycle 0 -> valid words cycles 1-4: 00000000, 00000000, C0A80101, 00000000; done=1 at cycle 5 only; busy high cycles 1-4.
2. ip=0A000001, k=2, pre=0, post=0, fill=FF -> FFFF0A00, 0001FFFF; done at cycle 3.
3. ip=01020304, k=3, pre=1, post=0, fill=00 -> 00000000, 00000001, 02030400; matcher downstream asserts match.
4. k=1, pre=5: pulse start again at cycles 2 and 7 -> ignored; exactly one stream of 7 words; single done.
5. k=0, pre=10: clear at cycle 4 -> from cycle 5 data_valid=0, busy=0, data_out=0, no done; new start at cycle 6 runs normally.
6. k=0, pre=10: n_rst low mid-PRE -> outputs zero immediately (async); after release, IDLE; start is accepted.
